// File: rtl/toggle_sequencer_fsm_pkg.sv
// Shared definitions for the toggle sequencer: the state encoding and a
// small state-decode helper used for the busy output.
package toggle_sequencer_fsm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_e;

  function automatic logic state_is_busy(input seq_state_e s);
    return (s == ST_RUN) || (s == ST_PAUSE);
  endfunction

endpackage

// File: rtl/toggle_sequencer_fsm_seq_period_timer.sv
// Half-period down-counter. A load takes priority over counting. While
// enabled, the counter decrements and then stops at zero. The zero flag marks
// the expiry cycle.
module seq_period_timer
  import toggle_sequencer_fsm_pkg::*;
#(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [DIV_W-1:0] load_val,
  input  logic             en,
  output logic             zero
);

  logic [DIV_W-1:0] count_q;

  // load / decrement / hold
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (en && (count_q != '0)) begin
      count_q <= count_q - DIV_W'(1);
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/toggle_sequencer_fsm.sv
// Toggle sequencer: emits a programmed number of output toggles, spaced by a
// programmed half-period. The sequencer supports pause and abort.
//
//   state    | meaning
//   ---------+--------------------------------------------------------
//   ST_IDLE  | waiting for start; out holds its last level
//   ST_RUN   | counting down the half-period and toggling at expiry
//   ST_PAUSE | frozen; timer, out and toggle count hold
//   ST_DONE  | one-cycle completion marker; start here chains a new run
module toggle_sequencer_fsm
  import toggle_sequencer_fsm_pkg::*;
#(
  parameter int CNT_W = 8,
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             pause,
  input  logic             abort,
  input  logic [DIV_W-1:0] half_period,
  input  logic [CNT_W-1:0] num_toggles,
  output logic             out,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] toggle_cnt
);

  seq_state_e       state_q, state_d;
  logic             out_q, out_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] hp_q, hp_d;
  logic [CNT_W-1:0] n_q, n_d;

  logic             tmr_load;
  logic [DIV_W-1:0] tmr_load_val;
  logic             tmr_en;
  logic             tmr_zero;
  logic [DIV_W-1:0] hp_eff;
  logic [CNT_W-1:0] cnt_inc;

  // A programmed half-period of zero behaves as one cycle.
  assign hp_eff  = (half_period == '0) ? DIV_W'(1) : half_period;
  assign cnt_inc = cnt_q + CNT_W'(1);

  seq_period_timer #(
    .DIV_W (DIV_W)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .en       (tmr_en),
    .zero     (tmr_zero)
  );

  // state, output level, toggle count and latched request registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      out_q   <= 1'b0;
      cnt_q   <= '0;
      hp_q    <= '0;
      n_q     <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      cnt_q   <= cnt_d;
      hp_q    <= hp_d;
      n_q     <= n_d;
    end
  end

  // next-state, timer control and datapath updates; abort wins over everything
  always_comb begin
    state_d      = state_q;
    out_d        = out_q;
    cnt_d        = cnt_q;
    hp_d         = hp_q;
    n_d          = n_q;
    tmr_load     = 1'b0;
    tmr_load_val = '0;
    tmr_en       = 1'b0;

    if (abort) begin
      state_d      = ST_IDLE;
      out_d        = 1'b0;
      tmr_load     = 1'b1;
      tmr_load_val = '0;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            hp_d         = hp_eff;
            n_d          = num_toggles;
            cnt_d        = '0;
            out_d        = 1'b0;
            tmr_load     = 1'b1;
            tmr_load_val = hp_eff - DIV_W'(1);
            state_d      = (num_toggles != '0) ? ST_RUN : ST_DONE;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_RUN: begin
          // The edge that enters PAUSE neither counts nor toggles.
          if (pause) begin
            state_d = ST_PAUSE;
          end else if (!tmr_zero) begin
            tmr_en = 1'b1;
          end else begin
            out_d        = ~out_q;
            cnt_d        = cnt_inc;
            tmr_load     = 1'b1;
            tmr_load_val = hp_q - DIV_W'(1);
            state_d      = (cnt_inc == n_q) ? ST_DONE : ST_RUN;
          end
        end
        ST_PAUSE: begin
          if (!pause) begin
            state_d = ST_RUN;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  assign out        = out_q;
  assign busy       = state_is_busy(state_q);
  assign done       = (state_q == ST_DONE);
  assign toggle_cnt = cnt_q;

endmodule

// File: tb/tb_toggle_sequencer_fsm.sv
// Bench for toggle_sequencer_fsm. Each driven cycle runs a behavioural model
// of the sequencer. The model result is queued and then compared with the
// outputs once the edge has happened. Directed checks confirm the timing
// points of each scenario.
module tb_toggle_sequencer_fsm;

  localparam int CNT_W = 8;
  localparam int DIV_W = 16;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0;
  logic             pause = 1'b0;
  logic             abort = 1'b0;
  logic [DIV_W-1:0] half_period = '0;
  logic [CNT_W-1:0] num_toggles = '0;
  logic             out;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] toggle_cnt;

  toggle_sequencer_fsm #(
    .CNT_W (CNT_W),
    .DIV_W (DIV_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .pause       (pause),
    .abort       (abort),
    .half_period (half_period),
    .num_toggles (num_toggles),
    .out         (out),
    .busy        (busy),
    .done        (done),
    .toggle_cnt  (toggle_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic             out;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // model state: 0 idle, 1 run, 2 pause, 3 done
  int               m_st;
  logic             m_out;
  logic [CNT_W-1:0] m_cnt;
  logic [CNT_W-1:0] m_n;
  logic [DIV_W-1:0] m_tmr;
  logic [DIV_W-1:0] m_hp;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st  = 0;
    m_out = 1'b0;
    m_cnt = '0;
    m_n   = '0;
    m_tmr = '0;
    m_hp  = '0;
  endtask

  task automatic model_edge();
    if (abort) begin
      m_st  = 0;
      m_out = 1'b0;
      m_tmr = '0;
    end else if (m_st == 0 || m_st == 3) begin
      if (start) begin
        m_hp  = (half_period == 0) ? 16'd1 : half_period;
        m_n   = num_toggles;
        m_cnt = '0;
        m_out = 1'b0;
        m_tmr = m_hp - 16'd1;
        m_st  = (m_n != 0) ? 1 : 3;
      end else begin
        m_st = 0;
      end
    end else if (m_st == 1) begin
      if (pause) begin
        m_st = 2;
      end else if (m_tmr != 0) begin
        m_tmr = m_tmr - 16'd1;
      end else begin
        m_out = ~m_out;
        m_cnt = m_cnt + 8'd1;
        m_tmr = m_hp - 16'd1;
        m_st  = (m_cnt == m_n) ? 3 : 1;
      end
    end else begin
      if (!pause) m_st = 1;
    end
  endtask

  // Drive one cycle and queue the model's prediction. After the edge, pop
  // the prediction and score it against the DUT outputs.
  task automatic step(input logic st, input logic pa, input logic ab,
                      input logic [DIV_W-1:0] hp, input logic [CNT_W-1:0] n);
    exp_t e;
    exp_t got;
    @(negedge clk);
    start       = st;
    pause       = pa;
    abort       = ab;
    half_period = hp;
    num_toggles = n;
    model_edge();
    e.out  = m_out;
    e.busy = (m_st == 1) || (m_st == 2);
    e.done = (m_st == 3);
    e.cnt  = m_cnt;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    got = exp_q.pop_front();
    check_eq("sb_out", out, got.out);
    check_eq("sb_busy", busy, got.busy);
    check_eq("sb_done", done, got.done);
    check_eq("sb_cnt", toggle_cnt, got.cnt);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int   busy_cyc;
    logic seen;
    logic hold_out;
    logic [CNT_W-1:0] hold_cnt;

    model_reset();
    #12;
    check_eq("rst_out", out, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_cnt", toggle_cnt, 0);
    @(negedge clk);
    reset = 1'b1;
    idle();

    // hp=3, n=4: toggles at E3, E6, E9 and E12, with done after E12
    step(1'b1, 1'b0, 1'b0, 16'd3, 8'd4);
    busy_cyc = busy;
    for (int k = 1; k <= 13; k++) begin
      idle();
      check_eq("t1_out", out, (k >= 12) ? 0 : (k / 3) % 2);
      check_eq("t1_done", done, (k == 12) ? 1 : 0);
      busy_cyc += busy;
    end
    check_eq("t1_busy_cycles", busy_cyc, 12);
    check_eq("t1_cnt", toggle_cnt, 4);

    // hp=2, n=3, with pause held for 5 cycles after E1
    step(1'b1, 1'b0, 1'b0, 16'd2, 8'd3);
    idle();
    hold_out = out;
    hold_cnt = toggle_cnt;
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 1'b1, 1'b0, '0, '0);
      check_eq("t2_hold_out", out, hold_out);
      check_eq("t2_hold_cnt", toggle_cnt, hold_cnt);
      check_eq("t2_paused_busy", busy, 1);
    end
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      idle();
      if (done) seen = 1'b1;
    end
    check_eq("t2_done_seen", seen, 1);
    check_eq("t2_cnt", toggle_cnt, 3);
    check_eq("t2_out", out, 1);
    idle();

    // half_period=0 behaves as 1
    step(1'b1, 1'b0, 1'b0, 16'd0, 8'd2);
    idle();
    check_eq("t3_out_e1", out, 1);
    idle();
    check_eq("t3_out_e2", out, 0);
    check_eq("t3_done_e2", done, 1);
    idle();
    check_eq("t3_idle_busy", busy, 0);
    // num_toggles=0 goes directly to DONE
    step(1'b1, 1'b0, 1'b0, 16'd5, 8'd0);
    check_eq("t3_n0_done", done, 1);
    check_eq("t3_n0_cnt", toggle_cnt, 0);
    check_eq("t3_n0_busy", busy, 0);
    idle();
    check_eq("t3_n0_after", done, 0);

    // abort after 2 of 5 toggles at hp=4
    step(1'b1, 1'b0, 1'b0, 16'd4, 8'd5);
    for (int k = 0; k < 8; k++) idle();
    check_eq("t4_cnt_before", toggle_cnt, 2);
    step(1'b0, 1'b0, 1'b1, '0, '0);
    check_eq("t4_busy", busy, 0);
    check_eq("t4_out", out, 0);
    check_eq("t4_cnt", toggle_cnt, 2);
    for (int k = 0; k < 3; k++) begin
      idle();
      check_eq("t4_no_done", done, 0);
    end
    // abort while out is high forces it low
    step(1'b1, 1'b0, 1'b0, 16'd1, 8'd5);
    idle();
    check_eq("t4b_out_high", out, 1);
    step(1'b0, 1'b0, 1'b1, '0, '0);
    check_eq("t4b_out_low", out, 0);
    check_eq("t4b_cnt", toggle_cnt, 1);

    // start held: ignored while busy, chained from DONE with new values
    step(1'b1, 1'b0, 1'b0, 16'd1, 8'd2);
    step(1'b1, 1'b0, 1'b0, 16'd3, 8'd1);
    check_eq("t5_cnt_e1", toggle_cnt, 1);
    step(1'b1, 1'b0, 1'b0, 16'd3, 8'd1);
    check_eq("t5_done_e2", done, 1);
    check_eq("t5_cnt_e2", toggle_cnt, 2);
    step(1'b1, 1'b0, 1'b0, 16'd3, 8'd1);
    check_eq("t5_chain_busy", busy, 1);
    check_eq("t5_chain_cnt", toggle_cnt, 0);
    idle();
    idle();
    check_eq("t5_no_toggle_yet", toggle_cnt, 0);
    idle();
    check_eq("t5_done_e6", done, 1);
    check_eq("t5_cnt_e6", toggle_cnt, 1);
    idle();

    // asynchronous reset in the middle of a run
    step(1'b1, 1'b0, 1'b0, 16'd3, 8'd6);
    for (int k = 0; k < 4; k++) idle();
    check_eq("t6_pre_out", out, 1);
    #2;
    reset = 1'b0;
    #1;
    check_eq("t6_rst_out", out, 0);
    check_eq("t6_rst_busy", busy, 0);
    check_eq("t6_rst_done", done, 0);
    check_eq("t6_rst_cnt", toggle_cnt, 0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    idle();
    check_eq("t6_idle_busy", busy, 0);

    // random traffic scored against the model
    for (int k = 0; k < 400; k++) begin
      step(($urandom_range(0, 9) == 0), ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 29) == 0), DIV_W'($urandom_range(0, 3)),
           CNT_W'($urandom_range(0, 4)));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
